// File: rtl/mem_game_pkg.sv
// Shared types for the card-matching game engine: FSM state encoding and per-card record.
package mem_game_pkg;

   // Wide enough for 16 pairs, the largest supported board.
   localparam int unsigned PAIR_ID_W = 4;

   typedef enum logic [3:0] {
      IDLE,
      DEAL,
      PREVIEW,
      HIDE,
      PICK1,
      PICK2,
      COMPARE,
      SHOW,
      OVER
   } game_state_t;

   typedef struct packed {
      logic                 matched;
      logic                 face_up;
      logic [PAIR_ID_W-1:0] pair_id;
   } card_t;

endpackage

// File: rtl/memory_game_engine_card_shuffler.sv
// card_shuffler: free-running 16-bit Fibonacci LFSR plus the descending Fisher-Yates swap sequencer.
module card_shuffler
   import mem_game_pkg::*;
#(
   parameter int unsigned N_CARDS = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       begin_deal,
   output logic                       swap_en,
   output logic [$clog2(N_CARDS)-1:0] swap_i,
   output logic [$clog2(N_CARDS)-1:0] swap_j,
   output logic                       swap_last
);

   localparam int unsigned IDX_W = $clog2(N_CARDS);

   logic [15:0]      lfsr_q;
   logic             busy_q;
   logic [IDX_W-1:0] idx_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= 16'hACE1;
         busy_q <= 1'b0;
         idx_q  <= '0;
      end else begin
         // Taps 16,14,13,11.
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         if (begin_deal) begin
            busy_q <= 1'b1;
            idx_q  <= IDX_W'(N_CARDS - 1);
         end else if (busy_q) begin
            if (idx_q == IDX_W'(1)) busy_q <= 1'b0;
            else                    idx_q  <= idx_q - IDX_W'(1);
         end
      end
   end

   always_comb begin
      swap_en   = busy_q;
      swap_i    = idx_q;
      swap_j    = IDX_W'(lfsr_q % (16'(idx_q) + 16'd1));
      swap_last = busy_q && (idx_q == IDX_W'(1));
   end

endmodule

// File: rtl/memory_game_engine.sv
// Board and turn engine for the card-matching game: deal, preview, picks, scoring, turn timer, winner.
// Define MEM_GAME_SHUFFLE_EN to shuffle the deal with an LFSR; otherwise the layout is fixed (pair_id=i>>1).
module memory_game_engine
   import mem_game_pkg::*;
#(
   parameter int unsigned N_CARDS       = 16,
   parameter int unsigned N_PLAYERS     = 2,
   parameter int unsigned TURN_SECS     = 15,
   parameter int unsigned PREVIEW_TICKS = 3,
   parameter int unsigned SHOW_TICKS    = 1
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              tick,
   input  logic                                              start,
   input  logic                                              sel_valid,
   input  logic [$clog2(N_CARDS)-1:0]                        sel_idx,
   output card_t [N_CARDS-1:0]                               board,
   output game_state_t                                       state,
   output logic [$clog2(N_PLAYERS)-1:0]                      cur_player,
   output logic [N_PLAYERS-1:0][$clog2(N_CARDS/2+1)-1:0]     scores,
   output logic [$clog2(TURN_SECS+1)-1:0]                    time_left,
   output logic                                              game_over,
   output logic [$clog2(N_PLAYERS)-1:0]                      winner,
   output logic                                              tie
);

   localparam int unsigned IDX_W   = $clog2(N_CARDS);
   localparam int unsigned PL_W    = $clog2(N_PLAYERS);
   localparam int unsigned SCORE_W = $clog2(N_CARDS/2+1);
   localparam int unsigned TL_W    = $clog2(TURN_SECS+1);
   localparam int unsigned CNT_MAX = (PREVIEW_TICKS > SHOW_TICKS) ? PREVIEW_TICKS : SHOW_TICKS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX+1);

   logic [CNT_W-1:0]   tick_cnt_q;
   logic [SCORE_W-1:0] pairs_found_q;
   logic [IDX_W-1:0]   pick_a_q, pick_b_q;

   card_t [N_CARDS-1:0]               dealt;
   logic [N_PLAYERS-1:0][SCORE_W-1:0] scores_inc;
   logic [SCORE_W-1:0]                best;
   logic [PL_W-1:0]                   win_c, next_player;
   logic                              tie_c, pick_ok, expiring;

`ifdef MEM_GAME_SHUFFLE_EN
   logic             deal_first_q;
   logic             swap_en, swap_last;
   logic [IDX_W-1:0] swap_i, swap_j;

   card_shuffler #(
      .N_CARDS (N_CARDS)
   ) u_shuffler (
      .clk        (clk),
      .rst        (rst),
      .begin_deal ((state == DEAL) && deal_first_q),
      .swap_en    (swap_en),
      .swap_i     (swap_i),
      .swap_j     (swap_j),
      .swap_last  (swap_last)
   );
`endif

   always_comb begin
      for (int i = 0; i < N_CARDS; i++) begin
         dealt[i].matched = 1'b0;
         dealt[i].face_up = 1'b1;  // cards stay face-up through PREVIEW
         dealt[i].pair_id = PAIR_ID_W'(i / 2);
      end
      next_player = (cur_player == PL_W'(N_PLAYERS - 1)) ? '0 : cur_player + PL_W'(1);
      pick_ok  = sel_valid && (32'(sel_idx) < N_CARDS) &&
                 !board[sel_idx].matched && !board[sel_idx].face_up;
      expiring = tick && (time_left == TL_W'(1));
   end

   // Winner is evaluated on the scores as they will be after the final match lands.
   always_comb begin
      scores_inc             = scores;
      scores_inc[cur_player] = scores[cur_player] + SCORE_W'(1);
      best  = scores_inc[0];
      win_c = '0;
      tie_c = 1'b0;
      for (int p = 1; p < N_PLAYERS; p++) begin
         if (scores_inc[p] > best) begin
            best  = scores_inc[p];
            win_c = PL_W'(p);
            tie_c = 1'b0;
         end else if (scores_inc[p] == best) begin
            tie_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         board         <= '0;
         scores        <= '0;
         cur_player    <= '0;
         time_left     <= TL_W'(TURN_SECS);
         game_over     <= 1'b0;
         winner        <= '0;
         tie           <= 1'b0;
         tick_cnt_q    <= '0;
         pairs_found_q <= '0;
         pick_a_q      <= '0;
         pick_b_q      <= '0;
`ifdef MEM_GAME_SHUFFLE_EN
         deal_first_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, OVER: begin
               if (start) begin
                  state         <= DEAL;
                  scores        <= '0;
                  cur_player    <= '0;
                  game_over     <= 1'b0;
                  winner        <= '0;
                  tie           <= 1'b0;
                  tick_cnt_q    <= '0;
                  pairs_found_q <= '0;
`ifdef MEM_GAME_SHUFFLE_EN
                  deal_first_q  <= 1'b1;
`endif
               end
            end
            DEAL: begin
`ifdef MEM_GAME_SHUFFLE_EN
               if (deal_first_q) begin
                  board        <= dealt;
                  deal_first_q <= 1'b0;
               end else if (swap_en) begin
                  board[swap_i] <= board[swap_j];
                  board[swap_j] <= board[swap_i];
                  if (swap_last) state <= PREVIEW;
               end
`else
               board <= dealt;
               state <= PREVIEW;
`endif
            end
            PREVIEW: begin
               if (tick) begin
                  if (tick_cnt_q == CNT_W'(PREVIEW_TICKS - 1)) begin
                     tick_cnt_q <= '0;
                     state      <= HIDE;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                  end
               end
            end
            HIDE: begin
               for (int i = 0; i < N_CARDS; i++) board[i].face_up <= 1'b0;
               time_left <= TL_W'(TURN_SECS);
               state     <= PICK1;
            end
            PICK1, PICK2: begin
               if (time_left == '0) begin
                  for (int i = 0; i < N_CARDS; i++) begin
                     if (!board[i].matched) board[i].face_up <= 1'b0;
                  end
                  cur_player <= next_player;
                  time_left  <= TL_W'(TURN_SECS);
                  state      <= PICK1;
               end else begin
                  if (tick) time_left <= time_left - TL_W'(1);
                  // A pick landing on the expiring tick loses to the timeout.
                  if (pick_ok && !expiring) begin
                     board[sel_idx].face_up <= 1'b1;
                     if (state == PICK1) begin
                        pick_a_q <= sel_idx;
                        state    <= PICK2;
                     end else begin
                        pick_b_q <= sel_idx;
                        state    <= COMPARE;
                     end
                  end
               end
            end
            COMPARE: begin
               if (board[pick_a_q].pair_id == board[pick_b_q].pair_id) begin
                  board[pick_a_q].matched <= 1'b1;
                  board[pick_b_q].matched <= 1'b1;
                  scores[cur_player]      <= scores_inc[cur_player];
                  pairs_found_q           <= pairs_found_q + SCORE_W'(1);
                  if (pairs_found_q == SCORE_W'(N_CARDS/2 - 1)) begin
                     state     <= OVER;
                     game_over <= 1'b1;
                     winner    <= win_c;
                     tie       <= tie_c;
                  end else begin
                     time_left <= TL_W'(TURN_SECS);
                     state     <= PICK1;
                  end
               end else begin
                  state <= SHOW;
               end
            end
            SHOW: begin
               if (tick) begin
                  if (tick_cnt_q == CNT_W'(SHOW_TICKS - 1)) begin
                     tick_cnt_q               <= '0;
                     board[pick_a_q].face_up  <= 1'b0;
                     board[pick_b_q].face_up  <= 1'b0;
                     cur_player               <= next_player;
                     time_left                <= TL_W'(TURN_SECS);
                     state                    <= PICK1;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_game_engine.sv
// Self-checking bench for memory_game_engine: scripted games with a scoreboard of expected turn results.
module tb_memory_game_engine;
   import mem_game_pkg::*;

   localparam int unsigned NC = 16;
   localparam int unsigned NP = 2;
   localparam int unsigned TS = 15;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              tick = 1'b0;
   logic              start = 1'b0;
   logic              sel_valid = 1'b0;
   logic [3:0]        sel_idx = '0;
   card_t [NC-1:0]    board;
   game_state_t       state;
   logic [0:0]        cur_player;
   logic [NP-1:0][3:0] scores;
   logic [3:0]        time_left;
   logic              game_over;
   logic [0:0]        winner;
   logic              tie;

   int n_checks = 0;
   int n_fail   = 0;
   int m_score[NP];
   int m_cur;
   int m_pairs;

   typedef struct {
      string tag;
      int    val;
   } exp_t;
   exp_t sb_q[$];

   memory_game_engine #(
      .N_CARDS       (NC),
      .N_PLAYERS     (NP),
      .TURN_SECS     (TS),
      .PREVIEW_TICKS (3),
      .SHOW_TICKS    (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start      (start),
      .sel_valid  (sel_valid),
      .sel_idx    (sel_idx),
      .board      (board),
      .state      (state),
      .cur_player (cur_player),
      .scores     (scores),
      .time_left  (time_left),
      .game_over  (game_over),
      .winner     (winner),
      .tie        (tie)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input int got);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq("sb_underflow", 0, 1);
      end else begin
         e = sb_q.pop_front();
         check_eq(e.tag, got, e.val);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step(1);
      tick = 1'b0;
   endtask

   task automatic pick(input int idx);
      sel_idx   = 4'(idx);
      sel_valid = 1'b1;
      step(1);
      sel_valid = 1'b0;
   endtask

   function automatic int face_count();
      int c = 0;
      for (int i = 0; i < NC; i++) c += int'(board[i].face_up);
      return c;
   endfunction

   task automatic check_reset(input string tag);
      sb_push({tag, "_state"}, int'(IDLE));
      sb_push({tag, "_board"}, 0);
      sb_push({tag, "_scores"}, 0);
      sb_push({tag, "_player"}, 0);
      sb_push({tag, "_time"}, TS);
      sb_push({tag, "_over_win_tie"}, 0);
      sb_pop(int'(state));
      sb_pop(int'(board != '0));
      sb_pop(int'(scores));
      sb_pop(int'(cur_player));
      sb_pop(int'(time_left));
      sb_pop(int'(game_over) + int'(winner) + int'(tie));
   endtask

   task automatic run_to_pick1();
      start = 1'b1;
      step(1);
      start = 1'b0;
      check_eq("deal_entry", int'(state), int'(DEAL));
      step(1);
      check_eq("preview_entry", int'(state), int'(PREVIEW));
      check_eq("preview_faces", face_count(), NC);
      repeat (3) pulse_tick();
      check_eq("hide_entry", int'(state), int'(HIDE));
      step(1);
      check_eq("pick1_entry", int'(state), int'(PICK1));
      check_eq("hidden_faces", face_count(), 0);
      check_eq("new_game_scores", int'(scores), 0);
      check_eq("new_game_player", int'(cur_player), 0);
      check_eq("new_game_time", int'(time_left), TS);
      m_score = '{0, 0};
      m_cur   = 0;
      m_pairs = 0;
   endtask

   // Model: fixed layout, card i belongs to pair i>>1.
   task automatic turn(input int a, input int b);
      bit match;
      match = (a >> 1) == (b >> 1);
      if (match) begin
         m_score[m_cur]++;
         m_pairs++;
      end
      sb_push("turn_state", !match ? int'(SHOW) : (m_pairs == NC/2) ? int'(OVER) : int'(PICK1));
      sb_push("turn_score", m_score[m_cur]);
      sb_push("turn_player", m_cur);
      pick(a);
      pick(b);
      step(1);
      sb_pop(int'(state));
      sb_pop(int'(scores[m_cur]));
      sb_pop(int'(cur_player));
      if (!match) begin
         sb_push("show_faces", 2);
         sb_pop(int'(board[a].face_up) + int'(board[b].face_up));
         pulse_tick();
         m_cur = (m_cur + 1) % NP;
         sb_push("show_end_state", int'(PICK1));
         sb_push("show_end_faces", 0);
         sb_push("show_end_player", m_cur);
         sb_push("show_end_time", TS);
         sb_pop(int'(state));
         sb_pop(int'(board[a].face_up) + int'(board[b].face_up));
         sb_pop(int'(cur_player));
         sb_pop(int'(time_left));
      end else begin
         sb_push("match_flags", 2);
         sb_pop(int'(board[a].matched) + int'(board[b].matched));
      end
   endtask

   initial begin
      step(2);
      check_reset("reset");
      rst = 1'b1;
      step(1);

`ifdef MEM_GAME_SHUFFLE_EN
      begin
         int n = 0;
         int cnt[NC/2];
         start = 1'b1;
         step(1);
         start = 1'b0;
         while (state == DEAL && n < 100) begin
            step(1);
            n++;
         end
         check_eq("deal_cycles", n, NC);
         check_eq("shuffle_preview", int'(state), int'(PREVIEW));
         for (int p = 0; p < NC/2; p++) cnt[p] = 0;
         for (int i = 0; i < NC; i++) cnt[board[i].pair_id % (NC/2)]++;
         for (int p = 0; p < NC/2; p++) check_eq($sformatf("pair_count_%0d", p), cnt[p], 2);
      end
`else
      // Game 1: preview/hide, match, mismatch, timeout paths, then P0 5 : P1 3.
      run_to_pick1();
      turn(0, 1);
      turn(2, 4);

      pick(4);
      check_eq("pick_face_up", int'(board[4].face_up), 1);
      pick(4);
      check_eq("repick_ignored", int'(state), int'(PICK2));
      repeat (14) pulse_tick();
      check_eq("timer_one", int'(time_left), 1);
      pulse_tick();
      check_eq("timer_zero", int'(time_left), 0);
      step(1);
      m_cur = (m_cur + 1) % NP;
      check_eq("timeout_state", int'(state), int'(PICK1));
      check_eq("timeout_hidden", int'(board[4].face_up), 0);
      check_eq("timeout_player", int'(cur_player), m_cur);
      check_eq("timeout_reload", int'(time_left), TS);

      pick(0);
      check_eq("matched_pick_ignored", int'(state), int'(PICK1));
      repeat (14) pulse_tick();
      tick      = 1'b1;
      sel_idx   = 4'd6;
      sel_valid = 1'b1;
      step(1);
      tick      = 1'b0;
      sel_valid = 1'b0;
      check_eq("coincident_zero", int'(time_left), 0);
      check_eq("coincident_dropped", int'(board[6].face_up), 0);
      check_eq("coincident_state", int'(state), int'(PICK1));
      step(1);
      m_cur = (m_cur + 1) % NP;
      check_eq("coincident_player", int'(cur_player), m_cur);

      turn(2, 3);
      turn(4, 5);
      turn(6, 7);
      turn(8, 10);
      turn(8, 9);
      turn(10, 11);
      turn(12, 13);
      turn(14, 15);
      check_eq("g1_game_over", int'(game_over), 1);
      check_eq("g1_p1_score", int'(scores[1]), 3);
      check_eq("g1_winner", int'(winner), 0);
      check_eq("g1_tie", int'(tie), 0);

      // Game 2: restart from OVER, 4 : 4 split.
      run_to_pick1();
      turn(0, 1);
      turn(2, 3);
      turn(4, 5);
      turn(6, 7);
      turn(8, 10);
      turn(8, 9);
      turn(10, 11);
      turn(12, 13);
      turn(14, 15);
      check_eq("g2_game_over", int'(game_over), 1);
      check_eq("g2_winner", int'(winner), 0);
      check_eq("g2_tie", int'(tie), 1);

      // Game 3: asynchronous abort in PICK2.
      run_to_pick1();
      pick(0);
      check_eq("abort_pick2", int'(state), int'(PICK2));
      #3 rst = 1'b0;
      #1 check_reset("abort");
      rst = 1'b1;
      step(2);
      check_eq("abort_stays_idle", int'(state), int'(IDLE));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
